// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between a read-only fetch port
// and a data load/store port.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_req/if_addr/if_gnt        fetch request, word address, same-cycle grant
//   if_flush                     drop the fetch response due this cycle
//   if_rvalid/if_rdata           fetch response, one cycle after grant
//   d_req/d_we/d_addr/d_wdata    data request (d_we == 0 means read)
//   d_gnt, d_rvalid/d_rdata      data grant and response (write ack or read data)
//   mem_addr/mem_wdata/mem_we/mem_re  memory drive for the winning request
//   mem_rdata                    memory read data, valid one cycle after mem_re
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  input  logic                    if_flush,
  output logic                    if_rvalid,
  output logic [WIDTH-1:0]        if_rdata,
  input  logic                    d_req,
  input  logic [WIDTH/8-1:0]      d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [WIDTH-1:0]        d_wdata,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [WIDTH-1:0]        d_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]        mem_wdata,
  output logic [WIDTH/8-1:0]      mem_we,
  output logic                    mem_re,
  input  logic [WIDTH-1:0]        mem_rdata
);

  localparam int unsigned BE_W  = WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  owner_e                  owner_q, owner_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;

  logic d_win, if_win, d_write, fetch_starved;

  // Arbitration: data wins unless fetch has been denied STARVE_LIMIT times.
  always_comb begin
    fetch_starved = (cnt_q >= CNT_W'(STARVE_LIMIT));
    d_write       = (d_we != '0);
    d_win         = !rst && d_req && (!if_req || !fetch_starved);
    if_win        = !rst && if_req && !d_win;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state: response owner, starvation count, held memory address/data.
  always_comb begin
    owner_d = OWN_NONE;
    cnt_d   = '0;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    if (d_win) begin
      owner_d = OWN_D;
    end else if (if_win) begin
      owner_d = OWN_IF;
    end
    // Count only cycles where fetch is asking and losing; saturate at the limit.
    if (if_req && !if_win) begin
      cnt_d = fetch_starved ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // Outputs: memory drive for the winner, responses routed by owner.
  always_comb begin
    if_gnt    = if_win;
    d_gnt     = d_win;
    mem_re    = if_win || (d_win && !d_write);
    mem_we    = d_win ? d_we : BE_W'(0);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (d_win) begin
      mem_addr = d_addr;
      if (d_write) begin
        mem_wdata = d_wdata;
      end
    end else if (if_win) begin
      mem_addr = if_addr;
    end
    // A flush only cancels the fetch response that is landing this cycle.
    if_rvalid = !rst && (owner_q == OWN_IF) && !if_flush;
    d_rvalid  = !rst && (owner_q == OWN_D);
    if_rdata  = rst ? '0 : mem_rdata;
    d_rdata   = rst ? '0 : mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW  = 10;
  localparam int W   = 64;
  localparam int BE  = 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_flush, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [W-1:0]  if_rdata;
  logic          d_req, d_gnt, d_rvalid;
  logic [BE-1:0] d_we;
  logic [AW-1:0] d_addr;
  logic [W-1:0]  d_wdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [BE-1:0] mem_we;
  logic          mem_re;
  logic [W-1:0]  mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .WIDTH(W), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_flush(if_flush),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] init_word(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
  endfunction

  // Memory environment: one-cycle read latency, byte-enabled writes.
  logic [W-1:0] env_mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) env_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_re) mem_rdata <= env_mem[mem_addr];
      for (int b = 0; b < BE; b++)
        if (mem_we[b]) env_mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  // Reference model: arbitration rule, pending response and its own memory image.
  logic [W-1:0] ref_mem [1024];
  initial begin
    int           denied;
    bit           pv, pf, pread, ed, ei;
    logic [W-1:0] pdata;
    logic [AW-1:0] last_addr, ea;
    denied = 0; pv = 0; pf = 0; pread = 0; pdata = '0; last_addr = '0; ea = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (rst) begin
        check("m_rst_if_gnt", 64'(if_gnt), 64'(0));
        check("m_rst_d_gnt", 64'(d_gnt), 64'(0));
        check("m_rst_mem_re", 64'(mem_re), 64'(0));
        check("m_rst_mem_we", 64'(mem_we), 64'(0));
        check("m_rst_if_rvalid", 64'(if_rvalid), 64'(0));
        check("m_rst_d_rvalid", 64'(d_rvalid), 64'(0));
        check("m_rst_mem_addr", 64'(mem_addr), 64'(0));
        denied = 0; pv = 0; pf = 0; pread = 0; last_addr = '0;
      end else begin
        ed = d_req && (!if_req || denied < LIM);
        ei = if_req && !ed;
        check("m_d_gnt", 64'(d_gnt), 64'(ed));
        check("m_if_gnt", 64'(if_gnt), 64'(ei));
        check("m_if_rvalid", 64'(if_rvalid), 64'(pv && pf && !if_flush));
        check("m_d_rvalid", 64'(d_rvalid), 64'(pv && !pf));
        if (pv && pf && !if_flush) check("m_if_rdata", if_rdata, pdata);
        if (pv && !pf && pread) check("m_d_rdata", d_rdata, pdata);
        if (ed) begin
          ea = d_addr;
          check("m_mem_re", 64'(mem_re), 64'(d_we == '0));
          check("m_mem_we", 64'(mem_we), 64'(d_we));
          if (d_we != '0) check("m_mem_wdata", mem_wdata, d_wdata);
        end else if (ei) begin
          ea = if_addr;
          check("m_mem_re", 64'(mem_re), 64'(1));
          check("m_mem_we", 64'(mem_we), 64'(0));
        end else begin
          ea = last_addr;
          check("m_mem_re", 64'(mem_re), 64'(0));
          check("m_mem_we", 64'(mem_we), 64'(0));
        end
        check("m_mem_addr", 64'(mem_addr), 64'(ea));
        denied = (if_req && !ei) ? ((denied < LIM) ? denied + 1 : LIM) : 0;
        pv = ed || ei;
        pf = ei;
        pread = ei || (ed && d_we == '0);
        if (pread) pdata = ref_mem[ea];
        if (ed && d_we != '0)
          for (int b = 0; b < BE; b++)
            if (d_we[b]) ref_mem[ea][b*8 +: 8] = d_wdata[b*8 +: 8];
        if (pv) last_addr = ea;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b1; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b1; d_we = '0; d_addr = '0; d_wdata = '0;
    smp(); smp();
    check("rst_if_gnt", 64'(if_gnt), 64'(0));
    check("rst_d_gnt", 64'(d_gnt), 64'(0));
    cyc();
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    cyc();

    // 1: fetch stream 0..3
    for (int i = 0; i < 4; i++) begin
      if_req = 1'b1; if_addr = AW'(i);
      smp();
      check("t1_if_gnt", 64'(if_gnt), 64'(1));
      if (i > 0) begin
        check("t1_if_rvalid", 64'(if_rvalid), 64'(1));
        check("t1_if_rdata", if_rdata, {32'hA5A5_0000 + 32'(i - 1), 32'h5A5A_0000 + 32'(i - 1)});
      end
      check("t1_d_rvalid", 64'(d_rvalid), 64'(0));
      cyc();
    end
    if_req = 1'b0;
    smp();
    check("t1_last_rdata", if_rdata, 64'hA5A5_0003_5A5A_0003);
    cyc();

    // 2: contention, data first then fetch
    d_req = 1'b1; d_addr = 10'h010; if_req = 1'b1; if_addr = 10'h020;
    smp();
    check("t2_d_gnt", 64'(d_gnt), 64'(1));
    check("t2_if_gnt0", 64'(if_gnt), 64'(0));
    cyc();
    d_req = 1'b0;
    smp();
    check("t2_d_rvalid", 64'(d_rvalid), 64'(1));
    check("t2_d_rdata", d_rdata, 64'hA5A5_0010_5A5A_0010);
    check("t2_if_gnt1", 64'(if_gnt), 64'(1));
    cyc();
    if_req = 1'b0;
    smp();
    check("t2_if_rvalid", 64'(if_rvalid), 64'(1));
    check("t2_if_rdata", if_rdata, 64'hA5A5_0020_5A5A_0020);
    cyc();

    // 3: starvation, fetch forced on cycles 5 and 10
    d_req = 1'b1; d_addr = 10'h030; if_req = 1'b1; if_addr = 10'h040;
    for (int c = 1; c <= 10; c++) begin
      smp();
      check("t3_if_gnt", 64'(if_gnt), 64'(c == 5 || c == 10));
      check("t3_d_gnt", 64'(d_gnt), 64'(!(c == 5 || c == 10)));
      cyc();
    end
    d_req = 1'b0; if_req = 1'b0;
    cyc();

    // 4: partial write then read back
    d_req = 1'b1; d_we = 8'h0F; d_addr = 10'h005; d_wdata = 64'hAABB_CCDD_1122_3344;
    smp();
    check("t4_mem_we", 64'(mem_we), 64'h0F);
    check("t4_mem_re", 64'(mem_re), 64'(0));
    cyc();
    d_we = '0;
    smp();
    check("t4_wr_ack", 64'(d_rvalid), 64'(1));
    cyc();
    d_req = 1'b0;
    smp();
    check("t4_rd_rvalid", 64'(d_rvalid), 64'(1));
    check("t4_rd_data", d_rdata, 64'hA5A5_0005_1122_3344);
    cyc();

    // 5: flush drops only the landing fetch response
    if_req = 1'b1; if_addr = 10'h050;
    cyc();
    if_addr = 10'h051; if_flush = 1'b1;
    smp();
    check("t5_flushed", 64'(if_rvalid), 64'(0));
    check("t5_if_gnt", 64'(if_gnt), 64'(1));
    cyc();
    if_req = 1'b0; if_flush = 1'b0;
    smp();
    check("t5_rvalid", 64'(if_rvalid), 64'(1));
    check("t5_rdata", if_rdata, 64'hA5A5_0051_5A5A_0051);
    cyc();

    // 6: reset right after a read grant
    d_req = 1'b1; d_addr = 10'h060;
    smp();
    check("t6_d_gnt", 64'(d_gnt), 64'(1));
    cyc();
    d_req = 1'b0; rst = 1'b1; if_req = 1'b1;
    smp();
    check("t6_rst_d_rvalid", 64'(d_rvalid), 64'(0));
    check("t6_rst_if_gnt", 64'(if_gnt), 64'(0));
    cyc();
    rst = 1'b0; if_req = 1'b0;
    smp();
    check("t6_post_d_rvalid", 64'(d_rvalid), 64'(0));
    check("t6_post_if_rvalid", 64'(if_rvalid), 64'(0));
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
